// File: rtl/rand_pkg.sv
// Shared types, widths and the limit-to-mask helper for the rand_sampler slice.
package rand_pkg;

    localparam int WORD_W   = 56;
    localparam int SAMPLE_W = 8;
    localparam int SLICES   = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN
    } state_t;

    // Smallest all-ones mask covering limit-1; limit 0 wraps to 8'hFF (full range).
    function automatic logic [SAMPLE_W-1:0] mask_from_limit(input logic [SAMPLE_W-1:0] lim);
        logic [SAMPLE_W-1:0] m;
        m = lim - 8'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/rand_fifo.sv
// Register-based FIFO with registered head output; push is refused when full
// even if a pop happens in the same cycle.
module rand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rand_sampler.sv
// Rejection sampler: slices a 56-bit LFSR word into bytes and queues those below limit.
// Optional statistics ports are enabled with RAND_SAMPLER_STATS_EN.
module rand_sampler
    import rand_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                En,
    input  logic [WORD_W-1:0]   rand_in,
    input  logic [SAMPLE_W-1:0] limit,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy
`ifdef RAND_SAMPLER_STATS_EN
    ,
    output logic [15:0]         reject_cnt,
    output logic [15:0]         word_cnt
`endif
);

    state_t              state_reg;
    logic [WORD_W-1:0]   word_q_reg;
    logic [SAMPLE_W-1:0] limit_q_reg;
    logic [2:0]          idx_reg;

    logic [SAMPLE_W-1:0] slice_bytes [SLICES];
    logic [SAMPLE_W-1:0] cand;
    logic                accept;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                advance;

    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            assign slice_bytes[gi] = word_q_reg[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    assign cand    = slice_bytes[idx_reg] & mask_from_limit(limit_q_reg);
    assign accept  = (limit_q_reg == '0) || (cand < limit_q_reg);
    assign push    = (state_reg == ST_SCAN) && accept && !fifo_full;
    // A rejected byte never waits; an accepted one waits only for FIFO space.
    assign advance = (state_reg == ST_SCAN) && (!accept || !fifo_full);
    assign pop     = sample_valid && sample_ready;

    assign sample_valid = !fifo_empty;
    assign busy         = (state_reg != ST_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            word_q_reg  <= '0;
            limit_q_reg <= '0;
            idx_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (En) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    word_q_reg  <= rand_in;
                    limit_q_reg <= limit;
                    idx_reg     <= '0;
                    state_reg   <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (advance) begin
                        if (idx_reg == 3'(SLICES - 1)) begin
                            idx_reg   <= '0;
                            state_reg <= En ? ST_LOAD : ST_IDLE;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    rand_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .srst  (Reset),
        .push  (push),
        .pop   (pop),
        .din   (cand),
        .dout  (sample),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef RAND_SAMPLER_STATS_EN
    logic [15:0] reject_cnt_reg;
    logic [15:0] word_cnt_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            reject_cnt_reg <= '0;
            word_cnt_reg   <= '0;
        end else begin
            if ((state_reg == ST_SCAN) && !accept && (reject_cnt_reg != 16'hFFFF)) begin
                reject_cnt_reg <= reject_cnt_reg + 16'd1;
            end
            if ((state_reg == ST_LOAD) && (word_cnt_reg != 16'hFFFF)) begin
                word_cnt_reg <= word_cnt_reg + 16'd1;
            end
        end
    end

    assign reject_cnt = reject_cnt_reg;
    assign word_cnt   = word_cnt_reg;
`endif

endmodule

// File: tb/tb_rand_sampler.sv
// Self-checking bench for rand_sampler: table vectors, corner sequences and a
// randomized run scored against a byte-filter reference model.
module tb_rand_sampler;

    logic        Clk;
    logic        Reset;
    logic        En;
    logic [55:0] rand_in;
    logic [7:0]  limit;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
`ifdef RAND_SAMPLER_STATS_EN
    logic [15:0] reject_cnt;
    logic [15:0] word_cnt;
`endif

    rand_sampler #(.FIFO_DEPTH(4)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .En           (En),
        .rand_in      (rand_in),
        .limit        (limit),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy)
`ifdef RAND_SAMPLER_STATS_EN
        ,
        .reject_cnt   (reject_cnt),
        .word_cnt     (word_cnt)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    bit         rnd_ready = 1'b0;

    typedef struct {
        logic [55:0] word;
        logic [7:0]  lim;
        int          n;
        logic [55:0] exp_bytes;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        if (rnd_ready) sample_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference: keep every masked byte that falls below the limit, low byte first.
    task automatic model_word(input logic [55:0] w, input logic [7:0] lim);
        int p;
        int m;
        int b;
        p = 1;
        while (p < int'(lim)) p = p * 2;
        m = (lim == 8'd0) ? 255 : p - 1;
        for (int i = 0; i < 7; i++) begin
            b = int'((w >> (8 * i)) & 56'hFF) & m;
            if (lim == 8'd0 || b < int'(lim)) exp_q.push_back(8'(b));
        end
    endtask

    // Pulse En from IDLE; the word and limit are only valid at the LOAD edge.
    task automatic start_word(input logic [55:0] w, input logic [7:0] lim);
        rand_in = w;
        limit   = lim;
        En      = 1'b1;
        tick();
        En = 1'b0;
        tick();
        rand_in = {$urandom, $urandom};
        limit   = 8'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (k < 400 && !(!busy && !sample_valid && exp_q.size() == 0)) begin
            tick();
            k++;
        end
        check({nm, "_done"}, 64'(k < 400), 64'd1);
        exp_q.delete();
    endtask

    always @(negedge Clk) begin
        if (!Reset && sample_valid && sample_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected none", sample);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("pop sample=%02h exp=%02h", sample, e);
                if (sample !== e) begin
                    n_err++;
                    $display("FAIL pop_value: got %0h expected %0h", sample, e);
                end
            end
        end
    end

    initial begin
        logic [55:0] w;
        logic [7:0]  lim;
`ifdef RAND_SAMPLER_STATS_EN
        logic [15:0] rej0;
`endif
        vecs[0] = '{56'h06_05_04_03_02_01_00, 8'd5,   5, 56'h00_00_04_03_02_01_00};
        vecs[1] = '{56'hFF_EE_DD_CC_BB_AA_99, 8'd0,   7, 56'hFF_EE_DD_CC_BB_AA_99};
        vecs[2] = '{56'hA5_3C_FF_81_7E_12_C9, 8'd1,   7, 56'h00_00_00_00_00_00_00};
        vecs[3] = '{56'h13_22_31_40_0F_06_05, 8'd4,   7, 56'h03_02_01_00_03_02_01};
        vecs[4] = '{56'hC7_C8_FF_00_63_C9_64, 8'd200, 4, 56'h00_00_00_C7_00_63_64};
        vecs[5] = '{56'h0E_0D_0C_0B_0A_09_08, 8'd6,   6, 56'h00_05_04_03_02_01_00};

        Reset = 1'b1; En = 1'b0; rand_in = '0; limit = '0; sample_ready = 1'b0;
        tick();
        tick();
        check("reset_valid",  64'(sample_valid), 64'd0);
        check("reset_busy",   64'(busy),         64'd0);
        check("reset_sample", 64'(sample),       64'd0);
        check("reset_idx",    64'(dut.idx_reg),  64'd0);
        Reset = 1'b0;
        tick();

        // Table vectors with a consumer that is always ready.
        sample_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            w = vecs[v].exp_bytes;
            for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(w[8*i +: 8]);
`ifdef RAND_SAMPLER_STATS_EN
            rej0 = reject_cnt;
`endif
            start_word(vecs[v].word, vecs[v].lim);
            wait_done($sformatf("vec%0d", v));
`ifdef RAND_SAMPLER_STATS_EN
            check($sformatf("vec%0d_rejects", v), 64'(reject_cnt - rej0), 64'(7 - vecs[v].n));
`endif
        end

        // First push lands on the third edge after En is seen in IDLE.
        sample_ready = 1'b0;
        w = 56'h77_66_55_44_33_22_11;
        model_word(w, 8'd0);
        rand_in = w; limit = 8'd0; En = 1'b1;
        tick();
        check("lat_e1_busy",  64'(busy),         64'd1);
        check("lat_e1_valid", 64'(sample_valid), 64'd0);
        En = 1'b0;
        tick();
        rand_in = {$urandom, $urandom};
        check("lat_e2_valid", 64'(sample_valid), 64'd0);
        tick();
        check("lat_e3_valid",  64'(sample_valid), 64'd1);
        check("lat_e3_sample", 64'(sample),       64'h11);
        sample_ready = 1'b1;
        wait_done("latency");

        // Full FIFO stalls SCAN at byte 4; draining releases the rest.
        sample_ready = 1'b0;
        w = 56'h1F_2E_3D_4C_5B_6A_79;
        model_word(w, 8'd0);
        start_word(w, 8'd0);
        for (int i = 0; i < 8; i++) tick();
        check("stall_valid",  64'(sample_valid), 64'd1);
        check("stall_busy",   64'(busy),         64'd1);
        check("stall_idx",    64'(dut.idx_reg),  64'd4);
        check("stall_sample", 64'(sample),       64'h79);
        sample_ready = 1'b1;
        wait_done("stall");

        // Reset mid-SCAN with two entries queued.
        sample_ready = 1'b0;
        start_word(56'hAB_CD_EF_01_23_45_67, 8'd0);
        tick();
        tick();
        check("rst_pre_valid", 64'(sample_valid), 64'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_valid",  64'(sample_valid), 64'd0);
        check("rst_busy",   64'(busy),         64'd0);
        check("rst_idx",    64'(dut.idx_reg),  64'd0);
        check("rst_sample", 64'(sample),       64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("rst_stays_idle", 64'(busy), 64'd0);

        // En dropped while idx=2: the word finishes and no further LOAD occurs.
        sample_ready = 1'b1;
        w = 56'h0A_1B_2C_3D_4E_5F_60;
        model_word(w, 8'd0);
        rand_in = w; limit = 8'd0; En = 1'b1;
        tick();
        tick();
        rand_in = {$urandom, $urandom};
        tick();
        tick();
        check("en_drop_idx", 64'(dut.idx_reg), 64'd2);
        En = 1'b0;
        wait_done("en_drop");
        for (int i = 0; i < 5; i++) tick();
        check("en_drop_idle",  64'(busy),         64'd0);
        check("en_drop_empty", 64'(sample_valid), 64'd0);

        // Randomized words and limits with a randomly stalling consumer.
        rnd_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            w = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       lim = 8'd0;
                1:       lim = 8'd1;
                2:       lim = 8'($urandom_range(2, 16));
                default: lim = 8'($urandom);
            endcase
            model_word(w, lim);
            start_word(w, lim);
            wait_done($sformatf("rand%0d", t));
        end
        rnd_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
